// File: rtl/serial_adder_if.sv
// Handshake and data bundle between a requester, the serial adder and a consumer.
// The requester/consumer side uses the master modport; the adder uses slave.
interface serial_adder_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  ovf,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output ovf,
        output busy
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: one K-bit slice per clock, W/K slices per operation,
// with the carry held in a register between slices and valid/ready on both sides.
module serial_adder #(
    parameter int unsigned W = 8,
    parameter int unsigned K = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int unsigned NSlice = W / K;
    localparam int unsigned CntW   = (NSlice > 1) ? $clog2(NSlice) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [K:0]      slice_sum;
    logic [W-1:0]    slice_ext;
    logic            carry_into_msb;
    logic            last_slice;

    always_comb begin
        slice_sum = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]} + {{K{1'b0}}, carry_q};
        slice_ext = W'(slice_sum[K-1:0]);
        // On the final slice bit K-1 is the word MSB; its carry-in is recovered from the sum bit.
        carry_into_msb = slice_sum[K-1] ^ a_q[K-1] ^ b_q[K-1];
        last_slice     = (cnt_q == CntW'(NSlice - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> K;
                b_d     = b_q >> K;
                sum_d   = (sum_q >> K) | (slice_ext << (W - K));
                carry_d = slice_sum[K];
                cnt_d   = cnt_q + CntW'(1);
                if (last_slice) begin
                    cout_d  = slice_sum[K];
                    ovf_d   = carry_into_msb ^ slice_sum[K];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: W=8 with K=1 and K=4, plus a full W=4 sweep at K=1 and K=2.
module tb_serial_adder;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    serial_adder_if #(.W(8)) bus8a ();
    serial_adder_if #(.W(8)) bus8b ();
    serial_adder_if #(.W(4)) bus4a ();
    serial_adder_if #(.W(4)) bus4b ();

    serial_adder #(.W(8), .K(1)) u_dut8_k1 (.clk(clk), .rst_n(rst_n), .bus(bus8a.slave));
    serial_adder #(.W(8), .K(4)) u_dut8_k4 (.clk(clk), .rst_n(rst_n), .bus(bus8b.slave));
    serial_adder #(.W(4), .K(1)) u_dut4_k1 (.clk(clk), .rst_n(rst_n), .bus(bus4a.slave));
    serial_adder #(.W(4), .K(2)) u_dut4_k2 (.clk(clk), .rst_n(rst_n), .bus(bus4b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Leaves the bench at the falling edge just after the acceptance edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub);
        @(negedge clk);
        check("k1_pre_in_ready", 32'(bus8a.in_ready), 32'd1);
        bus8a.in_valid = 1'b1;
        bus8a.a        = a;
        bus8a.b        = b;
        bus8a.cin      = cin;
        bus8a.sub      = sub;
        @(posedge clk);
        @(negedge clk);
        bus8a.in_valid = 1'b0;
        check("k1_busy_run", 32'(bus8a.busy), 32'd1);
        check("k1_in_ready_run", 32'(bus8a.in_ready), 32'd0);
    endtask

    task automatic wait_valid8(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!bus8a.out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n), 32'(exp_lat));
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input logic [7:0] es,
                       input logic ec, input logic eo);
        bus8a.out_ready = 1'b1;
        start8(a, b, cin, sub);
        wait_valid8({tag, "_lat"}, 8);
        check({tag, "_sum"}, 32'(bus8a.sum), 32'(es));
        check({tag, "_cout"}, 32'(bus8a.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(bus8a.ovf), 32'(eo));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_in_ready_after"}, 32'(bus8a.in_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(bus8a.out_valid), 32'd0);
        check({tag, "_sum_held"}, 32'(bus8a.sum), 32'(es));
    endtask

    task automatic op8k4(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input logic [7:0] es,
                         input logic ec, input logic eo);
        int n;
        @(negedge clk);
        bus8b.in_valid = 1'b1;
        bus8b.a        = a;
        bus8b.b        = b;
        bus8b.cin      = cin;
        bus8b.sub      = sub;
        @(posedge clk);
        @(negedge clk);
        bus8b.in_valid = 1'b0;
        n = 0;
        while (!bus8b.out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(n), 32'd2);
        check({tag, "_sum"}, 32'(bus8b.sum), 32'(es));
        check({tag, "_cout"}, 32'(bus8b.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(bus8b.ovf), 32'(eo));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ref4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic sub, output logic [3:0] s, output logic c, output logic o);
        logic [3:0] bb;
        logic [4:0] full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {4'd0, (sub ? 1'b1 : cin)};
        s    = full[3:0];
        c    = full[4];
        o    = (a[3] == bb[3]) && (s[3] != a[3]);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic sub);
        logic [3:0] es, sa, sb;
        logic       ec, eo, ca, cb, oa, ob, got_a, got_b;
        int         n, lat_a, lat_b;
        ref4(a, b, cin, sub, es, ec, eo);
        @(negedge clk);
        {bus4a.a, bus4a.b, bus4a.cin, bus4a.sub, bus4a.in_valid} = {a, b, cin, sub, 1'b1};
        {bus4b.a, bus4b.b, bus4b.cin, bus4b.sub, bus4b.in_valid} = {a, b, cin, sub, 1'b1};
        @(posedge clk);
        @(negedge clk);
        bus4a.in_valid = 1'b0;
        bus4b.in_valid = 1'b0;
        {got_a, got_b, sa, sb, ca, cb, oa, ob} = '0;
        lat_a = -1;
        lat_b = -1;
        n = 0;
        while (!(got_a && got_b && bus4a.in_ready && bus4b.in_ready) && n < 16) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus4a.out_valid && !got_a) begin
                got_a = 1'b1;
                lat_a = n;
                {sa, ca, oa} = {bus4a.sum, bus4a.cout, bus4a.ovf};
            end
            if (bus4b.out_valid && !got_b) begin
                got_b = 1'b1;
                lat_b = n;
                {sb, cb, ob} = {bus4b.sum, bus4b.cout, bus4b.ovf};
            end
        end
        check("w4k1_lat", 32'(lat_a), 32'd4);
        check("w4k2_lat", 32'(lat_b), 32'd2);
        check("w4k1_res", {27'd0, ca, oa, sa}, {27'd0, ec, eo, es});
        check("w4k2_res", {27'd0, cb, ob, sb}, {27'd0, ec, eo, es});
    endtask

    initial begin
        int seen;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        {bus8a.in_valid, bus8a.a, bus8a.b, bus8a.cin, bus8a.sub} = '0;
        {bus8b.in_valid, bus8b.a, bus8b.b, bus8b.cin, bus8b.sub} = '0;
        {bus4a.in_valid, bus4a.a, bus4a.b, bus4a.cin, bus4a.sub} = '0;
        {bus4b.in_valid, bus4b.a, bus4b.b, bus4b.cin, bus4b.sub} = '0;
        bus8a.out_ready = 1'b1;
        bus8b.out_ready = 1'b1;
        bus4a.out_ready = 1'b1;
        bus4b.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sum", 32'(bus8a.sum), 32'd0);
        check("rst_cout_ovf", {30'd0, bus8a.cout, bus8a.ovf}, 32'd0);
        check("rst_out_valid", 32'(bus8a.out_valid), 32'd0);
        check("rst_busy", 32'(bus8a.busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus8a.in_ready), 32'd1);

        op8("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_7f_cin", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Backpressure: stall five cycles while a competing request is offered.
        bus8a.out_ready = 1'b0;
        start8(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_valid8("bp_lat", 8);
        for (int i = 0; i < 5; i++) begin
            {bus8a.in_valid, bus8a.a, bus8a.b, bus8a.sub} = {1'b1, 8'hAA, 8'h55, 1'b1};
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(bus8a.out_valid), 32'd1);
            check("bp_sum", 32'(bus8a.sum), 32'h10);
            check("bp_cout", 32'(bus8a.cout), 32'd0);
            check("bp_in_ready", 32'(bus8a.in_ready), 32'd0);
        end
        bus8a.in_valid  = 1'b0;
        bus8a.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 32'(bus8a.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus8a.in_ready), 32'd1);
        check("bp_release_sum", 32'(bus8a.sum), 32'h10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_not_queued", 32'(bus8a.busy), 32'd0);

        // Abort in RUN: reset lands on the third slice edge.
        start8(8'hF0, 8'h0F, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_sum", 32'(bus8a.sum), 32'd0);
        check("abort_cout_ovf", {30'd0, bus8a.cout, bus8a.ovf}, 32'd0);
        check("abort_out_valid", 32'(bus8a.out_valid), 32'd0);
        check("abort_busy", 32'(bus8a.busy), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus8a.out_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        op8("post_abort", 8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);

        op8k4("k4_9c_6b", 8'h9C, 8'h6B, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0);
        op8k4("k4_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8k4("k4_sub", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);

        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        op4(4'(a), 4'(b), 1'(c), 1'(s));
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
